// File: rtl/ram2video_scaled.sv
// Line-buffer to video timing generator with vertical line repeat and optional
// scanline darkening. Reads one buffer word per picture pixel and emits
// {R,G,B} with syncs and data enable, two clocks after the read address.
module ram2video_scaled #(
   parameter int unsigned H_TOTAL      = 858,
   parameter int unsigned H_VISIBLE    = 720,
   parameter int unsigned H_SYNC_START = 736,
   parameter int unsigned H_SYNC_WIDTH = 62,
   parameter bit          H_SYNC_POL   = 1'b0,
   parameter int unsigned V_TOTAL      = 525,
   parameter int unsigned V_VISIBLE    = 480,
   parameter int unsigned V_SYNC_START = 489,
   parameter int unsigned V_SYNC_WIDTH = 6,
   parameter bit          V_SYNC_POL   = 1'b0,
   parameter int unsigned H_OFFSET     = 40,
   parameter int unsigned V_OFFSET     = 0,
   parameter int unsigned LINE_LEN     = 640,
   parameter int unsigned ADDR_BITS    = 15,
   parameter int unsigned DEPTH        = 2 ** ADDR_BITS,
   parameter int unsigned CH_W         = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 starttrigger,
   input  logic [1:0]           line_repeat,
   input  logic                 scanline_en,
   input  logic [4:0]           scanline_level,
   input  logic [3*CH_W-1:0]    rddata,
   output logic [ADDR_BITS-1:0] rdaddr,
   output logic [3*CH_W-1:0]    video_out,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic                 restart,
   output logic                 frame_start
);

   localparam int unsigned XW = $clog2(H_TOTAL);
   localparam int unsigned YW = $clog2(V_TOTAL);
   localparam int unsigned PW = 3 * CH_W;

   localparam logic [XW-1:0] XLast  = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] XPicLo = XW'(H_OFFSET);
   localparam logic [XW-1:0] XPicHi = XW'(H_VISIBLE - H_OFFSET);
   localparam logic [XW-1:0] XVis   = XW'(H_VISIBLE);
   localparam logic [XW-1:0] XHsLo  = XW'(H_SYNC_START);
   localparam logic [XW-1:0] XHsHi  = XW'(H_SYNC_START + H_SYNC_WIDTH);
   localparam logic [YW-1:0] YLast  = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] YPicLo = YW'(V_OFFSET);
   localparam logic [YW-1:0] YPicHi = YW'(V_VISIBLE - V_OFFSET);
   localparam logic [YW-1:0] YVis   = YW'(V_VISIBLE);
   localparam logic [YW-1:0] YVsLo  = YW'(V_SYNC_START);
   localparam logic [YW-1:0] YVsHi  = YW'(V_SYNC_START + V_SYNC_WIDTH);

   localparam logic [ADDR_BITS-1:0] XaddrMax = ADDR_BITS'(LINE_LEN - 1);
   localparam logic [ADDR_BITS-1:0] LineLen  = ADDR_BITS'(LINE_LEN);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic [YW-1:0]        y_q, y_d;
   logic [1:0]           sub_q, sub_d;
   logic [ADDR_BITS-1:0] base_q, base_d;
   logic [ADDR_BITS-1:0] xaddr_q, xaddr_d;
   logic [1:0]           lr_q;
   logic                 restart_q, restart_d;

   logic                 de1_q, hs1_q, vs1_q, pic1_q, scan1_q;
   logic                 de_q, hs_q, vs_q;
   logic [PW-1:0]        video_q, pix_d;

   logic                 run;
   logic                 vs_area;
   logic [XW-1:0]        x_next;

   function automatic logic pic_x(input logic [XW-1:0] x);
      return (x >= XPicLo) && (x < XPicHi);
   endfunction

   function automatic logic pic_y(input logic [YW-1:0] y);
      return (y >= YPicLo) && (y < YPicHi);
   endfunction

   // Channel gain in sixteenths; levels above 16 clamp to unity.
   function automatic logic [CH_W-1:0] dim(input logic [CH_W-1:0] c, input logic [4:0] lvl);
      logic [4:0]      g;
      logic [CH_W+4:0] p;
      g = (lvl > 5'd16) ? 5'd16 : lvl;
      p = {5'b0, c} * {{CH_W{1'b0}}, g};
      return p[CH_W+3:4];
   endfunction

   assign run    = (state_q == StRun);
   assign x_next = (x_q == XLast) ? '0 : x_q + 1'b1;

   // Next state, counters and buffer addressing.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      sub_d     = sub_q;
      base_d    = base_q;
      xaddr_d   = xaddr_q;
      restart_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (starttrigger) begin
               state_d   = StRun;
               restart_d = 1'b1;
            end
         end
         StRun: begin
            if (line_repeat != lr_q) begin
               state_d = StIdle;
            end else begin
               x_d = x_next;
               if (pic_x(x_next)) begin
                  if (pic_x(x_q)) xaddr_d = (xaddr_q == XaddrMax) ? xaddr_q : xaddr_q + 1'b1;
                  else            xaddr_d = '0;
               end else begin
                  xaddr_d = '0;
               end
               if (x_q == XLast) begin
                  y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
                  if (y_q == YLast) begin
                     sub_d  = '0;
                     base_d = '0;
                  end else if (pic_y(y_q)) begin
                     if (sub_q == line_repeat) begin
                        sub_d = '0;
                        // Wrap rather than let a source line run past the buffer end.
                        if (int'(base_q) + 2 * int'(LINE_LEN) > int'(DEPTH)) base_d = '0;
                        else                                                 base_d = base_q + LineLen;
                     end else begin
                        sub_d = sub_q + 1'b1;
                     end
                  end
               end
            end
         end
      endcase
      if (state_d != state_q) begin
         x_d     = XPicLo;
         y_d     = YPicLo;
         sub_d   = '0;
         base_d  = '0;
         xaddr_d = '0;
      end
   end

   // State, counter and control registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         x_q       <= XPicLo;
         y_q       <= YPicLo;
         sub_q     <= '0;
         base_q    <= '0;
         xaddr_q   <= '0;
         lr_q      <= '0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         sub_q     <= sub_d;
         base_q    <= base_d;
         xaddr_q   <= xaddr_d;
         lr_q      <= line_repeat;
         restart_q <= restart_d;
      end
   end

   assign rdaddr      = (run && pic_x(x_q) && pic_y(y_q)) ? base_q + xaddr_q : '0;
   assign frame_start = run && (x_q == '0) && (y_q == '0);

   // vsync edges are aligned to the hsync leading edge.
   assign vs_area = ((y_q == YVsLo) && (x_q >= XHsLo)) ||
                    ((y_q > YVsLo) && (y_q < YVsHi)) ||
                    ((y_q == YVsHi) && (x_q < XHsLo));

   // Pixel data for the second pipeline stage, darkened on scanlines.
   always_comb begin
      pix_d = '0;
      if (pic1_q) begin
         pix_d = rddata;
         if (scan1_q && scanline_en) begin
            for (int c = 0; c < 3; c++) begin
               pix_d[c*CH_W +: CH_W] = dim(rddata[c*CH_W +: CH_W], scanline_level);
            end
         end
      end
   end

   // Two-stage output pipeline matching the one-cycle buffer read latency.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         de1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         pic1_q  <= 1'b0;
         scan1_q <= 1'b0;
         de_q    <= 1'b0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         video_q <= '0;
      end else if (state_d != StRun) begin
         de1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         pic1_q  <= 1'b0;
         scan1_q <= 1'b0;
         de_q    <= 1'b0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         video_q <= '0;
      end else begin
         de1_q   <= run && (x_q < XVis) && (y_q < YVis);
         hs1_q   <= run && (x_q >= XHsLo) && (x_q < XHsHi);
         vs1_q   <= run && vs_area;
         pic1_q  <= run && pic_x(x_q) && pic_y(y_q);
         scan1_q <= run && (line_repeat != 2'd0) && (sub_q == line_repeat);
         de_q    <= de1_q;
         hs_q    <= hs1_q;
         vs_q    <= vs1_q;
         video_q <= pix_d;
      end
   end

   assign video_out = video_q;
   assign de        = de_q;
   assign hsync     = hs_q ? H_SYNC_POL : ~H_SYNC_POL;
   assign vsync     = vs_q ? V_SYNC_POL : ~V_SYNC_POL;
   assign restart   = restart_q;

endmodule
